muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Execute-stage consumer of the 5-bit ALUControl code from the decode stage. Handles the RV32M operations the single-cycle ALU does not finish in one cycle.
- Multiply takes 2 cycles. Divide/remainder uses a 32-iteration restoring divider.
- Sits beside the ALU in EX. The pipeline holds the M-instruction in EX while busy=1 and captures result on done=1.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; accepted only when IDLE and ALUControl is an M-op.
- ALUControl  input  5  op code: MUL=01010, MULH=01011, MULHSU=01100, MULHU=01101, DIV=01110, DIVU=01111, REM=10000, REMU=10001.
- SrcA  input  32  rs1 operand (dividend / multiplicand).
- SrcB  input  32  rs2 operand (divisor / multiplier).
- flush  input  1  abort the in-flight operation (branch mispredict / trap).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  32  operation result; held until the next done.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0. Overrides start and flush.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If start=1 and ALUControl is an M-op, latch SrcA, SrcB and the op at accept edge T.
  - Non-M codes with start=1 are ignored: stay IDLE, no done.
- Multiply path (IDLE->MUL->DONE):
  - In MUL, form the 64-bit product. MULH is signed x signed, MULHSU is signed x unsigned, MULHU and MUL are unsigned.
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
  - done=1 in cycle T+2.
- Divide path, normal case (IDLE->DIV->DONE):
  - Signed ops divide magnitudes. Quotient sign is sign(A) xor sign(B); remainder sign is sign(A).
  - DIV runs 32 iterations with a 6-bit counter, 0..31, one quotient bit per cycle.
  - done=1 in cycle T+33.
- Divide path, special cases (IDLE->DONE directly, done=1 at T+1):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcA.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: done=1 and busy=1 for exactly one cycle with result updated; then IDLE unconditionally.
- start asserted while busy=1 is ignored; there is no queueing. The next accept can occur in the first IDLE cycle after DONE.
- flush=1 in any non-IDLE state: next state IDLE, busy=0 next cycle, done never pulses for that op, result unchanged.
  - flush=1 coinciding with start in IDLE: start is not accepted.
  - flush=1 in DONE: done still pulses that cycle and the state returns to IDLE.
- Operand inputs may change after accept; only the latched copies are used.

Test Plan:
- MUL 7 x 6 (start at T) -> done=1 only at T+2, result=0x0000002A; busy high T+1..T+2.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0x00000002 -> result=0xFFFFFFFF.
- DIV -20 / 3 -> result=0xFFFFFFFA (-6) at T+33.
- REM -20 / 3 -> result=0xFFFFFFFE (-2).
- DIVU 100 / 7 -> result=14.
- Special cases: DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Abort and blocking:
  - Start DIVU, assert flush at T+10 -> busy=0 at T+11, no done, result keeps its prior value.
  - start re-pulsed at T+5 during a DIV -> ignored; single done at T+33.
- Reset:
  - Assert rst at T+3 during a DIV -> busy=0, done=0, result=0 next cycle.
  - start with ALUControl=00000 (ADD) -> busy stays 0, no done.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage pipeline control and the
// multi-cycle RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [4:0]            ALUControl;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, ALUControl, SrcA, SrcB, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, ALUControl, SrcA, SrcB, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: 2-cycle multiply, 32-iteration restoring
// divide/remainder, with single-cycle handling of divide-by-zero and overflow.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int         W         = DATA_WIDTH;
    localparam logic [5:0] LAST_ITER = 6'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    typedef enum logic [4:0] {
        OP_MUL    = 5'b01010,
        OP_MULH   = 5'b01011,
        OP_MULHSU = 5'b01100,
        OP_MULHU  = 5'b01101,
        OP_DIV    = 5'b01110,
        OP_DIVU   = 5'b01111,
        OP_REM    = 5'b10000,
        OP_REMU   = 5'b10001
    } op_t;

    state_t         state_q, state_d;
    op_t            op_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   quo_q, rem_q, dvs_q;
    logic           neg_q;
    logic [5:0]     count_q;
    logic [W-1:0]   result_q, result_d;

    // ---------------- request decode ----------------
    logic           is_m_op, is_div_op, is_rem_op, is_signed_div;
    logic           a_neg, b_neg, div_zero, div_ovf, accept;
    logic [W-1:0]   abs_a, abs_b, special_result;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        is_m_op       = 1'b0;
        is_div_op     = 1'b0;
        is_rem_op     = 1'b0;
        is_signed_div = 1'b0;
        case (bus.ALUControl)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_m_op = 1'b1;
            OP_DIV: begin
                is_m_op = 1'b1; is_div_op = 1'b1; is_signed_div = 1'b1;
            end
            OP_DIVU: begin
                is_m_op = 1'b1; is_div_op = 1'b1;
            end
            OP_REM: begin
                is_m_op = 1'b1; is_div_op = 1'b1; is_rem_op = 1'b1; is_signed_div = 1'b1;
            end
            OP_REMU: begin
                is_m_op = 1'b1; is_div_op = 1'b1; is_rem_op = 1'b1;
            end
            default: ;
        endcase
    end

    assign a_neg    = is_signed_div & bus.SrcA[W-1];
    assign b_neg    = is_signed_div & bus.SrcB[W-1];
    assign abs_a    = a_neg ? -bus.SrcA : bus.SrcA;
    assign abs_b    = b_neg ? -bus.SrcB : bus.SrcB;
    assign div_zero = (bus.SrcB == '0);
    assign div_ovf  = is_signed_div && (bus.SrcA == {1'b1, {(W-1){1'b0}}}) && (bus.SrcB == '1);
    assign accept   = (state_q == ST_IDLE) && bus.start && is_m_op && !bus.flush;

    // Overflow leaves SrcA (the most negative value) as the quotient.
    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = is_rem_op ? bus.SrcA : '1;
        else
            special_result = is_rem_op ? '0 : bus.SrcA;
    end

    // ---------------- multiplier ----------------
    logic           a_sext, b_sext;
    logic [2*W-1:0] product;
    logic [W-1:0]   mul_result;

    assign a_sext     = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[W-1];
    assign b_sext     = (op_q == OP_MULH) & b_q[W-1];
    assign product    = {{W{a_sext}}, a_q} * {{W{b_sext}}, b_q};
    assign mul_result = (op_q == OP_MUL) ? product[W-1:0] : product[2*W-1:W];

    // ---------------- restoring divider step ----------------
    logic [W:0]     shifted, diff;
    logic           fits;
    logic [W-1:0]   rem_next, quo_next, div_pick, div_result;

    assign shifted    = {rem_q, quo_q[W-1]};
    assign diff       = shifted - {1'b0, dvs_q};
    assign fits       = ~diff[W];
    assign rem_next   = fits ? diff[W-1:0] : shifted[W-1:0];
    assign quo_next   = {quo_q[W-2:0], fits};
    assign div_pick   = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_next : quo_next;
    assign div_result = neg_q ? -div_pick : div_pick;

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div_op) begin
                        state_d = ST_MUL;
                    end else if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_result;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_DONE;
                    result_d = mul_result;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (count_q == LAST_ITER) begin
                    state_d  = ST_DONE;
                    result_d = div_result;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q    <= op_t'(bus.ALUControl);
                a_q     <= bus.SrcA;
                b_q     <= bus.SrcB;
                quo_q   <= abs_a;
                dvs_q   <= abs_b;
                rem_q   <= '0;
                neg_q   <= is_rem_op ? a_neg : (a_neg ^ b_neg);
                count_q <= '0;
            end else if (state_q == ST_DIV) begin
                quo_q   <= quo_next;
                rem_q   <= rem_next;
                count_q <= count_q + 6'd1;
            end
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
endmodule
